// File: rtl/dsp_mem_arbiter.sv
// Two-port burst arbiter/sequencer for the shared coefficient memory; grant to first beat 1 cycle, one access per cycle, read data +1 cycle.
// Round-robin on ties by default; define DSP_MEM_ARB_FIXED_PRIO_EN to make port 0 always win ties.
module dsp_mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 14,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic              done0,
   output logic              done1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t            state;
   logic              sel;
   logic              bwe;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  blen;
   logic [LEN_W-1:0]  cnt;
   logic              any_req;
   logic              pick;
   logic              in_burst;
   logic              last_beat;
   logic              rd_beat;

   assign any_req = req0 | req1;

   // pick is the port index that wins arbitration this IDLE cycle
`ifdef DSP_MEM_ARB_FIXED_PRIO_EN
   assign pick = ~req0;
`else
   logic rr_last;
   assign pick = (req0 & req1) ? ~rr_last : req1;
`endif

   assign in_burst  = (state == BURST);
   assign last_beat = in_burst && (cnt == blen);
   assign rd_beat   = in_burst & ~bwe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= 1'b0;
         bwe     <= 1'b0;
         base    <= '0;
         blen    <= '0;
         cnt     <= '0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata   <= '0;
`ifndef DSP_MEM_ARB_FIXED_PRIO_EN
         rr_last <= 1'b1;
`endif
      end else begin
         rvalid0 <= rd_beat & ~sel;
         rvalid1 <= rd_beat & sel;
         if (rd_beat) begin
            rdata <= mem_dout;
         end
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= BURST;
                  sel   <= pick;
                  bwe   <= pick ? we1 : we0;
                  base  <= pick ? addr1 : addr0;
                  blen  <= pick ? len1 : len0;
                  cnt   <= '0;
               end
            end
            BURST: begin
               if (last_beat) begin
                  state <= IDLE;
`ifndef DSP_MEM_ARB_FIXED_PRIO_EN
                  rr_last <= sel;
`endif
               end else begin
                  cnt <= cnt + LEN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign gnt0  = (state == IDLE) & any_req & ~pick;
   assign gnt1  = (state == IDLE) & any_req & pick;
   assign ack0  = in_burst & ~sel;
   assign ack1  = in_burst & sel;
   assign done0 = last_beat & ~sel;
   assign done1 = last_beat & sel;

   // address wraps naturally modulo the memory depth
   assign mem_en   = in_burst;
   assign mem_we   = in_burst & bwe;
   assign mem_addr = in_burst ? (base + ADDR_W'(cnt)) : '0;
   assign mem_din  = in_burst ? (sel ? wdata1 : wdata0) : '0;

endmodule
